// File: rtl/fft_r2sdf_stage_if.sv
// fft_r2sdf_stage_if: streaming sample bus of an R2SDF FFT stage.
// Carries the input sample, the twiddle ROM address and data, and the output sample.
// master = sample source / ROM / sink side; slave = the FFT stage.
interface fft_r2sdf_stage_if #(
  parameter int DW = 32,
  parameter int TW = 16,
  parameter int AW = 4
);
  logic                 in_valid;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;
  logic [AW-1:0]        tw_addr;
  logic signed [TW-1:0] tw_r;
  logic signed [TW-1:0] tw_i;
  logic                 out_valid;
  logic                 out_sop;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  modport master (output in_valid, in_r, in_i, tw_r, tw_i, input tw_addr, out_valid, out_sop, out_r, out_i);
  modport slave (input in_valid, in_r, in_i, tw_r, tw_i, output tw_addr, out_valid, out_sop, out_r, out_i);
endinterface

// File: rtl/fft_r2sdf_stage.sv
// fft_r2sdf_stage: radix-2 single-path delay-feedback DIF FFT stage, one sample per valid cycle.
// Ports: clk, rst (sync, active-high), bus (slave): in_valid/in_r/in_i sample in,
// tw_addr out with tw_r/tw_i returned combinationally, out_valid/out_sop/out_r/out_i sample out.
// Optional macro FFT_STAGE_SCALE_EN: butterfly sum/diff halved (arith shift) instead of wrapped.
module fft_r2sdf_stage #(
  parameter int DW = 32,
  parameter int TW = 16,
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int TW_STRIDE = 1
) (
  input logic clk,
  input logic rst,
  fft_r2sdf_stage_if.slave bus
);
  localparam int LD = DEPTH > 1 ? $clog2(DEPTH) : 0;
  localparam int PW = DW + TW + 1;
  typedef logic signed [PW-1:0] p_t;
  typedef logic signed [DW:0] s_t;
  logic [LD:0] cnt;
  logic primed;
  logic signed [DW-1:0] dl_r [DEPTH];
  logic signed [DW-1:0] dl_i [DEPTH];
  logic signed [DW-1:0] head_r, head_i, red_sum_r, red_sum_i, red_dif_r, red_dif_i;
  logic phase;
  logic [31:0] k;
  s_t sum_r, sum_i, dif_r, dif_i;
  logic s1_v, s1_sop, s1_sel;
  logic signed [DW-1:0] s1_sum_r, s1_sum_i;
  p_t s1_p_r, s1_p_i, rnd_r, rnd_i;
  assign head_r = dl_r[DEPTH-1];
  assign head_i = dl_i[DEPTH-1];
  assign phase = cnt[LD];
  assign k = 32'(cnt) & 32'(DEPTH - 1);
  assign bus.tw_addr = AW'(k * 32'(TW_STRIDE));
  assign sum_r = s_t'(head_r) + s_t'(bus.in_r);
  assign sum_i = s_t'(head_i) + s_t'(bus.in_i);
  assign dif_r = s_t'(head_r) - s_t'(bus.in_r);
  assign dif_i = s_t'(head_i) - s_t'(bus.in_i);
`ifdef FFT_STAGE_SCALE_EN
  assign red_sum_r = DW'(sum_r >>> 1);
  assign red_sum_i = DW'(sum_i >>> 1);
  assign red_dif_r = DW'(dif_r >>> 1);
  assign red_dif_i = DW'(dif_i >>> 1);
`else
  assign red_sum_r = DW'(sum_r);
  assign red_sum_i = DW'(sum_i);
  assign red_dif_r = DW'(dif_r);
  assign red_dif_i = DW'(dif_i);
`endif
  // round half up at the Q2.(TW-2) binary point
  assign rnd_r = s1_p_r + p_t'(1 << (TW - 3));
  assign rnd_i = s1_p_i + p_t'(1 << (TW - 3));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      primed <= 1'b0;
      s1_v <= 1'b0;
      s1_sop <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sop <= 1'b0;
      bus.out_r <= '0;
      bus.out_i <= '0;
    end else begin
      s1_v <= bus.in_valid && (phase || primed);
      s1_sop <= bus.in_valid && phase && k == 0;
      bus.out_valid <= s1_v;
      bus.out_sop <= s1_sop;
      bus.out_r <= !s1_v ? '0 : s1_sel ? DW'(rnd_r >>> (TW - 2)) : s1_sum_r;
      bus.out_i <= !s1_v ? '0 : s1_sel ? DW'(rnd_i >>> (TW - 2)) : s1_sum_i;
      if (bus.in_valid) begin
        cnt <= cnt + 1'b1;
        if (&cnt) primed <= 1'b1;
      end
    end
  end
  // delay line and stage-1 data carry no reset; validity is tracked by the reset valids
  always_ff @(posedge clk) begin
    s1_sel <= !phase;
    s1_sum_r <= red_sum_r;
    s1_sum_i <= red_sum_i;
    s1_p_r <= p_t'(head_r) * p_t'(bus.tw_r) - p_t'(head_i) * p_t'(bus.tw_i);
    s1_p_i <= p_t'(head_r) * p_t'(bus.tw_i) + p_t'(head_i) * p_t'(bus.tw_r);
    if (bus.in_valid) begin
      dl_r[0] <= phase ? red_dif_r : bus.in_r;
      dl_i[0] <= phase ? red_dif_i : bus.in_i;
      for (int j = 1; j < DEPTH; j++) begin
        dl_r[j] <= dl_r[j-1];
        dl_i[j] <= dl_i[j-1];
      end
    end
  end
endmodule
